flit_inject_buffer: RTL

FLIT_INJECT_BUFFER -- requirements
Module: flit_inject_buffer

---
 rtl/flit_inject_buffer_pkg.sv | 14 +
 rtl/flit_inject_buffer_fifo.sv | 67 ++++++
 rtl/flit_inject_buffer.sv | 110 +++++++++++
 3 files changed

// File: rtl/flit_inject_buffer_pkg.sv
// Shared types and constants for the flit injection buffer.
//   pkt_state_e  : output-side packet tracking states
//   SIZE_FIELD_W : width of the payload-length field carried in the size flit
package PhiversPkg;

  localparam int SIZE_FIELD_W = 16;

  typedef enum logic [1:0] {
    PKT_HEADER  = 2'd0,
    PKT_SIZE    = 2'd1,
    PKT_PAYLOAD = 2'd2
  } pkt_state_e;

endpackage

// File: rtl/flit_inject_buffer_fifo.sv
// flit_fifo: circular flit store with wrapping pointers and an occupancy counter.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset (pointers/count only)
//   push_i, data_i  : write request and flit (ignored when full)
//   pop_i           : read request (ignored when empty)
//   data_o          : current head flit, combinational
//   full_o, empty_o : occupancy flags
module flit_fifo #(
  parameter int FLIT_SIZE    = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 pop_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(BUFFER_DEPTH);

  logic [FLIT_SIZE-1:0] mem_q [BUFFER_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 push, pop;

  assign full_o  = (cnt_q == (AW+1)'(BUFFER_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Power-of-two depth: pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because
  // empty_o gates tx at the top level.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/flit_inject_buffer.sv
// flit_inject_buffer: buffers flits from the task parser toward the many-core
// injection port, tracks packet boundaries on the output side and produces a
// qualified end-of-applications indication.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   eoa_i                  : end-of-applications pulse/level (sticky)
//   rx_i, data_i, credit_o : upstream valid / flit / credit (not full)
//   tx_o, data_o, credit_i : downstream valid (not empty) / head flit / credit
//   eoa_o                  : EOA seen, FIFO drained and no partial packet
//   pkt_active_o           : packet partially forwarded
//   pkt_count_o            : packets fully forwarded since reset (wraps)
module flit_inject_buffer
  import PhiversPkg::*;
#(
  parameter int FLIT_SIZE    = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 eoa_i,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 eoa_o,
  output logic                 pkt_active_o,
  output logic [15:0]          pkt_count_o
);

  logic                    full, empty, push, pop;
  pkt_state_e              state_q, state_d;
  logic [SIZE_FIELD_W-1:0] rem_q, rem_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    eoa_flag_q, eoa_flag_d;
  logic                    eoa_q, eoa_d;

  assign credit_o = ~full;
  assign tx_o     = ~empty;
  assign push     = rx_i & ~full;
  assign pop      = ~empty & credit_i;

  flit_fifo #(
    .FLIT_SIZE    (FLIT_SIZE),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (data_i),
    .pop_i   (pop),
    .data_o  (data_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      PKT_HEADER: if (pop) state_d = PKT_SIZE;
      PKT_SIZE: if (pop) begin
        rem_d = data_o[SIZE_FIELD_W-1:0];
        // Zero-length packet ends on its size flit.
        if (data_o[SIZE_FIELD_W-1:0] == '0) begin
          state_d = PKT_HEADER;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          state_d = PKT_PAYLOAD;
        end
      end
      PKT_PAYLOAD: if (pop) begin
        rem_d = rem_q - SIZE_FIELD_W'(1);
        if (rem_q == SIZE_FIELD_W'(1)) begin
          state_d = PKT_HEADER;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = PKT_HEADER;
    endcase
  end

  // EOA qualifies on the registered view of flag/FIFO/FSM, so it rises one
  // cycle after the last condition becomes true.
  assign eoa_flag_d = eoa_flag_q | eoa_i;
  assign eoa_d      = eoa_flag_q & empty & (state_q == PKT_HEADER);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= PKT_HEADER;
      rem_q      <= '0;
      cnt_q      <= '0;
      eoa_flag_q <= 1'b0;
      eoa_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      eoa_flag_q <= eoa_flag_d;
      eoa_q      <= eoa_d;
    end
  end

  assign eoa_o        = eoa_q;
  assign pkt_active_o = (state_q != PKT_HEADER);
  assign pkt_count_o  = cnt_q;

endmodule
